// File: rtl/roce_cm_pkg.sv
// Shared definitions for the RoCE connection-manager channel (transmitter and receiver).
// Holds the payload geometry, the byte offsets of every field inside the 44-byte
// payload, the packed record carried across the channel, and a big-endian byte placer.
package roce_cm_pkg;

  localparam int unsigned CM_PAYLOAD_BYTES = 44;
  localparam logic [15:0] CM_UDP_LENGTH    = 16'd52;
  localparam logic [63:0] CM_TKEEP         = 64'h0000_0FFF_FFFF_FFFF;

  // Byte offsets into the payload (byte 0 sits in tdata[7:0])
  localparam int unsigned OFF_FLAGS0      = 0;
  localparam int unsigned OFF_REM_QPN     = 1;
  localparam int unsigned OFF_LOC_QPN     = 4;
  localparam int unsigned OFF_REM_PSN     = 7;
  localparam int unsigned OFF_LOC_PSN     = 10;
  localparam int unsigned OFF_R_KEY       = 13;
  localparam int unsigned OFF_REM_BASE    = 17;
  localparam int unsigned OFF_FLAGS1      = 25;
  localparam int unsigned OFF_TX_REM_IP   = 26;
  localparam int unsigned OFF_TX_OFFSET   = 30;
  localparam int unsigned OFF_TX_DMA_LEN  = 38;
  localparam int unsigned OFF_TX_UDP_PORT = 42;

  typedef struct packed {
    logic        qp_valid;
    logic [23:0] rem_qpn;
    logic [23:0] loc_qpn;
    logic [23:0] rem_psn;
    logic [23:0] loc_psn;
    logic [31:0] r_key;
    logic [63:0] rem_base_addr;
    logic        tx_valid;
    logic        tx_start;
    logic        tx_write_type;
    logic [31:0] tx_rem_ip_addr;
    logic [63:0] tx_rem_addr_offset;
    logic [31:0] tx_dma_length;
    logic [15:0] tx_rem_udp_port;
  } cm_record_t;

  // Writes the low nbytes of val into d starting at byte lane off, most significant
  // byte first (lowest lane), matching network byte order on the wire.
  function automatic logic [511:0] put_be(input logic [511:0] d, input int unsigned off,
                                          input int unsigned nbytes, input logic [63:0] val);
    logic [511:0] r;
    r = d;
    for (int unsigned i = 0; i < nbytes; i++) begin
      r[(off + i) * 8 +: 8] = val[(nbytes - 1 - i) * 8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/roce_cm_meta_pack.sv
// Combinational packer: connection-manager record -> 512-bit payload beat.
// Ports: rec (cm_record_t, input), tdata (512-bit payload, output; bytes 44..63 are zero).
module roce_cm_meta_pack
  import roce_cm_pkg::*;
(
  input  cm_record_t   rec,
  output logic [511:0] tdata
);

  always_comb begin
    logic [511:0] d;
    d = '0;
    d[OFF_FLAGS0 * 8]  = rec.qp_valid;
    d = put_be(d, OFF_REM_QPN,     3, 64'(rec.rem_qpn));
    d = put_be(d, OFF_LOC_QPN,     3, 64'(rec.loc_qpn));
    d = put_be(d, OFF_REM_PSN,     3, 64'(rec.rem_psn));
    d = put_be(d, OFF_LOC_PSN,     3, 64'(rec.loc_psn));
    d = put_be(d, OFF_R_KEY,       4, 64'(rec.r_key));
    d = put_be(d, OFF_REM_BASE,    8, rec.rem_base_addr);
    d[OFF_FLAGS1 * 8 +: 3] = {rec.tx_write_type, rec.tx_start, rec.tx_valid};
    d = put_be(d, OFF_TX_REM_IP,   4, 64'(rec.tx_rem_ip_addr));
    d = put_be(d, OFF_TX_OFFSET,   8, rec.tx_rem_addr_offset);
    d = put_be(d, OFF_TX_DMA_LEN,  4, 64'(rec.tx_dma_length));
    d = put_be(d, OFF_TX_UDP_PORT, 2, 64'(rec.tx_rem_udp_port));
    tdata = d;
  end

endmodule

// File: rtl/udp_roce_cm_meta_tx_512.sv
// RoCE connection-manager transmitter: captures one QP-info + TX-metadata record and
// emits a UDP header plus a single 512-bit, 44-byte payload beat.
// Ports: clk, rst (sync, active-low); s_req_* record request handshake and fields;
// m_udp_hdr_* / m_ip_* / m_udp_* header channel; m_udp_payload_axis_* payload channel;
// frames_sent (completed-frame counter, wraps); busy (frame in flight).
module udp_roce_cm_meta_tx_512
  import roce_cm_pkg::*;
#(
  parameter logic [15:0] DEST_UDP_PORT = 16'h4321,
  parameter logic [15:0] SRC_UDP_PORT  = 16'h4321,
  parameter logic [7:0]  IP_TTL        = 8'd64,
  parameter logic [5:0]  IP_DSCP       = 6'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_req_valid,
  output logic         s_req_ready,
  input  logic         s_qp_valid,
  input  logic         s_tx_valid,
  input  logic         s_tx_start,
  input  logic         s_tx_write_type,
  input  logic [23:0]  s_rem_qpn,
  input  logic [23:0]  s_loc_qpn,
  input  logic [23:0]  s_rem_psn,
  input  logic [23:0]  s_loc_psn,
  input  logic [31:0]  s_r_key,
  input  logic [63:0]  s_rem_base_addr,
  input  logic [31:0]  s_tx_rem_ip_addr,
  input  logic [63:0]  s_tx_rem_addr_offset,
  input  logic [31:0]  s_tx_dma_length,
  input  logic [15:0]  s_tx_rem_udp_port,
  input  logic [31:0]  s_dest_ip,
  input  logic [31:0]  s_src_ip,
  output logic         m_udp_hdr_valid,
  input  logic         m_udp_hdr_ready,
  output logic [5:0]   m_ip_dscp,
  output logic [1:0]   m_ip_ecn,
  output logic [7:0]   m_ip_ttl,
  output logic [31:0]  m_ip_source_ip,
  output logic [31:0]  m_ip_dest_ip,
  output logic [15:0]  m_udp_source_port,
  output logic [15:0]  m_udp_dest_port,
  output logic [15:0]  m_udp_length,
  output logic [15:0]  m_udp_checksum,
  output logic [511:0] m_udp_payload_axis_tdata,
  output logic [63:0]  m_udp_payload_axis_tkeep,
  output logic         m_udp_payload_axis_tvalid,
  input  logic         m_udp_payload_axis_tready,
  output logic         m_udp_payload_axis_tlast,
  output logic         m_udp_payload_axis_tuser,
  output logic [31:0]  frames_sent,
  output logic         busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]   state;
  logic         hdr_valid;
  logic         pay_valid;
  logic [31:0]  frames_q;
  logic [31:0]  src_ip_q;
  logic [31:0]  dest_ip_q;
  cm_record_t   rec_q;
  cm_record_t   req_rec;
  logic [511:0] packed_data;
  logic         hdr_done;
  logic         pay_done;

  always_comb begin
    req_rec                    = '0;
    req_rec.qp_valid           = s_qp_valid;
    req_rec.rem_qpn            = s_rem_qpn;
    req_rec.loc_qpn            = s_loc_qpn;
    req_rec.rem_psn            = s_rem_psn;
    req_rec.loc_psn            = s_loc_psn;
    req_rec.r_key              = s_r_key;
    req_rec.rem_base_addr      = s_rem_base_addr;
    req_rec.tx_valid           = s_tx_valid;
    req_rec.tx_start           = s_tx_start;
    req_rec.tx_write_type      = s_tx_write_type;
    req_rec.tx_rem_ip_addr     = s_tx_rem_ip_addr;
    req_rec.tx_rem_addr_offset = s_tx_rem_addr_offset;
    req_rec.tx_dma_length      = s_tx_dma_length;
    req_rec.tx_rem_udp_port    = s_tx_rem_udp_port;
  end

  roce_cm_meta_pack u_pack (
    .rec   (rec_q),
    .tdata (packed_data)
  );

  // A channel counts as done once its valid has already dropped or it handshakes now.
  assign hdr_done = !hdr_valid || m_udp_hdr_ready;
  assign pay_done = !pay_valid || m_udp_payload_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      hdr_valid <= 1'b0;
      pay_valid <= 1'b0;
      frames_q  <= '0;
      rec_q     <= '0;
      src_ip_q  <= '0;
      dest_ip_q <= '0;
    end else if (state == IDLE) begin
      if (s_req_valid) begin
        rec_q     <= req_rec;
        src_ip_q  <= s_src_ip;
        dest_ip_q <= s_dest_ip;
        hdr_valid <= 1'b1;
        pay_valid <= 1'b1;
        state     <= SEND;
      end
    end else begin
      if (hdr_valid && m_udp_hdr_ready) hdr_valid <= 1'b0;
      if (pay_valid && m_udp_payload_axis_tready) pay_valid <= 1'b0;
      if (hdr_done && pay_done) begin
        state    <= IDLE;
        frames_q <= frames_q + 32'd1;
      end
    end
  end

  assign s_req_ready = rst && (state == IDLE);
  assign busy        = (state != IDLE);
  assign frames_sent = frames_q;

  // Header and payload fields read as zero whenever their channel is idle.
  assign m_udp_hdr_valid   = hdr_valid;
  assign m_ip_dscp         = hdr_valid ? IP_DSCP : '0;
  assign m_ip_ecn          = '0;
  assign m_ip_ttl          = hdr_valid ? IP_TTL : '0;
  assign m_ip_source_ip    = hdr_valid ? src_ip_q : '0;
  assign m_ip_dest_ip      = hdr_valid ? dest_ip_q : '0;
  assign m_udp_source_port = hdr_valid ? SRC_UDP_PORT : '0;
  assign m_udp_dest_port   = hdr_valid ? DEST_UDP_PORT : '0;
  assign m_udp_length      = hdr_valid ? CM_UDP_LENGTH : '0;
  assign m_udp_checksum    = '0;

  assign m_udp_payload_axis_tvalid = pay_valid;
  assign m_udp_payload_axis_tdata  = pay_valid ? packed_data : '0;
  assign m_udp_payload_axis_tkeep  = pay_valid ? CM_TKEEP : '0;
  assign m_udp_payload_axis_tlast  = pay_valid;
  assign m_udp_payload_axis_tuser  = 1'b0;

endmodule
